// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

  typedef enum logic [1:0] {
    HEADER  = 2'd0,
    PAYLOAD = 2'd1,
    RUN     = 2'd2,
    ERROR   = 2'd3
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned INSTR_W        = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus bundle: byte stream in, memory write port out, processor control.
interface imem_loader_if
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
);

  logic               in_valid;
  logic [BYTE_W-1:0]  in_data;
  logic               in_ready;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  logic               cpu_reset;
  logic               cpu_halt;
  logic               load_done;
  logic               load_err;
  logic [ADDR_W:0]    words_loaded;

  // System side: byte source, memory and processor.
  modport master (
    output in_valid, in_data, cpu_halt,
    input  in_ready, mem_we, mem_addr, mem_wdata,
    input  cpu_reset, load_done, load_err, words_loaded
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data, cpu_halt,
    output in_ready, mem_we, mem_addr, mem_wdata,
    output cpu_reset, load_done, load_err, words_loaded
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs big-endian bytes into 32-bit words; word_done flags the 4th byte combinationally.
module byte_packer
  import loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               byte_en,
  input  logic [BYTE_W-1:0]  byte_in,
  input  logic               clear,
  output logic [INSTR_W-1:0] word_out,
  output logic               word_done
);

  logic [LANE_W-1:0]  r_lane;
  logic [INSTR_W-1:0] r_shift;

  // Word including the byte presented this cycle, so the top can register it on the same edge.
  assign word_out  = (r_shift << BYTE_W) | INSTR_W'(byte_in);
  assign word_done = byte_en && (r_lane == LANE_W'(BYTES_PER_WORD - 1));

  // Lane counter and shift register; clear wins so partial words never cross a state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lane  <= '0;
      r_shift <= '0;
    end else if (clear) begin
      r_lane  <= '0;
      r_shift <= '0;
    end else if (byte_en) begin
      r_lane  <= r_lane + LANE_W'(1);
      r_shift <= word_out;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader: parses word-count header, writes instructions, gates processor reset.
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_e             r_state;
  logic [CNT_W-1:0]   r_words;
  logic [CNT_W-1:0]   r_count;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [INSTR_W-1:0] r_mem_wdata;
  logic               r_cpu_reset;
  logic               r_load_done;
  logic               r_load_err;

  logic               w_in_ready;
  logic               w_accept;
  logic [INSTR_W-1:0] w_word;
  logic               w_word_done;
  logic               w_hdr_done;
  logic               w_hdr_over;
  logic [CNT_W-1:0]   w_words_inc;
  logic               w_last_word;
  logic               w_halt;
  logic               w_clear;

  // Ready depends on state only; held low while reset is asserted.
  assign w_in_ready  = ((r_state == HEADER) || (r_state == PAYLOAD)) && !reset;
  assign w_accept    = bus.in_valid && w_in_ready;

  assign w_hdr_done  = (r_state == HEADER) && w_word_done;
  assign w_hdr_over  = w_word > INSTR_W'(DEPTH);
  assign w_words_inc = r_words + CNT_W'(1);
  assign w_last_word = (r_state == PAYLOAD) && w_word_done && (w_words_inc == r_count);
  assign w_halt      = (r_state == RUN) && bus.cpu_halt;
  assign w_clear     = w_hdr_done || w_last_word || w_halt;

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .byte_en   (w_accept),
    .byte_in   (bus.in_data),
    .clear     (w_clear),
    .word_out  (w_word),
    .word_done (w_word_done)
  );

  // Load FSM with registered memory-write and processor-control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= HEADER;
      r_words     <= '0;
      r_count     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_reset <= 1'b1;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        HEADER: begin
          if (w_word_done) begin
            r_words <= '0;
            r_count <= w_word[CNT_W-1:0];
            if (w_hdr_over) begin
              r_state    <= ERROR;
              r_load_err <= 1'b1;
            end else if (w_word == '0) begin
              r_state     <= RUN;
              r_cpu_reset <= 1'b0;
              r_load_done <= 1'b1;
            end else begin
              r_state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (w_word_done) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_words[ADDR_W-1:0];
            r_mem_wdata <= w_word;
            r_words     <= w_words_inc;
            // Processor leaves reset together with the final write.
            if (w_words_inc == r_count) begin
              r_state     <= RUN;
              r_cpu_reset <= 1'b0;
              r_load_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.cpu_halt) begin
            r_state     <= HEADER;
            r_cpu_reset <= 1'b1;
            r_load_done <= 1'b0;
          end
        end
        ERROR: begin
          r_load_err  <= 1'b1;
          r_cpu_reset <= 1'b1;
        end
        default: r_state <= HEADER;
      endcase
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.mem_we       = r_mem_we;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.cpu_reset    = r_cpu_reset;
  assign bus.load_done    = r_load_done;
  assign bus.load_err     = r_load_err;
  assign bus.words_loaded = r_words;

endmodule
